alu_unit: RTL and testbench

- Single-cycle integer execution unit for RV32I arithmetic, compare, branch-condition and jump-address operations.
- Instantiated inside the reservation station, which issues one ready instruction per cycle with operands, opcode class and ROB tag.
- Drives the RS-side CDB broadcast (tag + value + valid).
- Pulses an instruction-fetch resume/redirect for JALR.

---
 rtl/riscv_pkg.sv | 51 +++++
 rtl/alu_compare.sv | 16 +
 rtl/alu_unit.sv | 154 +++++++++++++++
 tb/tb_alu_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I widths and opcode encodings for the RS-side integer unit.
// Opcode layout: [6:4] class, [3:0] sub-op.
package riscv_pkg;

  localparam int VAL_WIDTH    = 32;
  localparam int ADDR_WIDTH   = 32;
  localparam int OP_WIDTH     = 7;
  localparam int ROB_ID_WIDTH = 4;

  localparam logic [2:0] OP_R_TYPE    = 3'b000;
  localparam logic [2:0] OP_I_TYPE    = 3'b001;
  localparam logic [2:0] OP_B_TYPE    = 3'b010;
  localparam logic [2:0] OP_MISC_TYPE = 3'b011;

  localparam logic [3:0] SUB_ADD  = 4'd0;
  localparam logic [3:0] SUB_SUB  = 4'd1;
  localparam logic [3:0] SUB_SLL  = 4'd2;
  localparam logic [3:0] SUB_SLT  = 4'd3;
  localparam logic [3:0] SUB_SLTU = 4'd4;
  localparam logic [3:0] SUB_XOR  = 4'd5;
  localparam logic [3:0] SUB_SRL  = 4'd6;
  localparam logic [3:0] SUB_SRA  = 4'd7;
  localparam logic [3:0] SUB_OR   = 4'd8;
  localparam logic [3:0] SUB_AND  = 4'd9;

  localparam logic [3:0] SUB_BEQ  = 4'd0;
  localparam logic [3:0] SUB_BNE  = 4'd1;
  localparam logic [3:0] SUB_BLT  = 4'd4;
  localparam logic [3:0] SUB_BGE  = 4'd5;
  localparam logic [3:0] SUB_BLTU = 4'd6;
  localparam logic [3:0] SUB_BGEU = 4'd7;

  localparam logic [3:0] SUB_LUI   = 4'd0;
  localparam logic [3:0] SUB_AUIPC = 4'd1;
  localparam logic [3:0] SUB_JAL   = 4'd2;
  localparam logic [3:0] SUB_JALR  = 4'd3;

  localparam logic [OP_WIDTH-1:0] OP_LUI   = {OP_MISC_TYPE, SUB_LUI};
  localparam logic [OP_WIDTH-1:0] OP_AUIPC = {OP_MISC_TYPE, SUB_AUIPC};
  localparam logic [OP_WIDTH-1:0] OP_JAL   = {OP_MISC_TYPE, SUB_JAL};
  localparam logic [OP_WIDTH-1:0] OP_JALR  = {OP_MISC_TYPE, SUB_JALR};

  function automatic logic [2:0] op_class(input logic [OP_WIDTH-1:0] op);
    return op[6:4];
  endfunction

  function automatic logic [3:0] op_sub(input logic [OP_WIDTH-1:0] op);
    return op[3:0];
  endfunction

endpackage

// File: rtl/alu_compare.sv
// Combinational equality / signed / unsigned less-than, shared by SLT(U) and branches.
module alu_compare #(
  parameter int W = 32
) (
  input  logic [W-1:0] val1,
  input  logic [W-1:0] val2,
  output logic         eq,
  output logic         lt,
  output logic         ltu
);

  assign eq  = (val1 == val2);
  assign lt  = ($signed(val1) < $signed(val2));
  assign ltu = (val1 < val2);

endmodule

// File: rtl/alu_unit.sv
// Single-cycle RV32I integer unit with registered CDB broadcast and JALR fetch redirect.
// Optional macro ALU_TRACE_EN adds a cycle counter and a simulation trace line per executed op.
module alu_unit
  import riscv_pkg::*;
#(
  parameter int VAL_WIDTH    = riscv_pkg::VAL_WIDTH,
  parameter int ADDR_WIDTH   = riscv_pkg::ADDR_WIDTH,
  parameter int OP_WIDTH     = riscv_pkg::OP_WIDTH,
  parameter int ROB_ID_WIDTH = riscv_pkg::ROB_ID_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    execute,
  input  logic [OP_WIDTH-1:0]     op_type,
  input  logic [VAL_WIDTH-1:0]    val1,
  input  logic [VAL_WIDTH-1:0]    val2,
  input  logic [ROB_ID_WIDTH-1:0] entry,
  input  logic [ADDR_WIDTH-1:0]   nowPC,
  output logic                    aluReady,
  output logic [ROB_ID_WIDTH-1:0] entry_out,
  output logic [VAL_WIDTH-1:0]    val_out,
  output logic [ADDR_WIDTH-1:0]   alu2if_pc,
  output logic                    alu2if_con
);

  localparam logic [VAL_WIDTH-1:0] ZERO_V = {VAL_WIDTH{1'b0}};
  localparam logic [VAL_WIDTH-1:0] LSB_V  = {{(VAL_WIDTH-1){1'b0}}, 1'b1};

  logic                 eq_s;
  logic                 lt_s;
  logic                 ltu_s;
  logic [2:0]           class_s;
  logic [3:0]           sub_s;
  logic [4:0]           shamt_s;
  logic [VAL_WIDTH-1:0] sum_s;
  logic [VAL_WIDTH-1:0] diff_s;
  logic [VAL_WIDTH-1:0] result_s;
  logic                 is_jalr_s;

  alu_compare #(.W(VAL_WIDTH)) u_cmp (
    .val1 (val1),
    .val2 (val2),
    .eq   (eq_s),
    .lt   (lt_s),
    .ltu  (ltu_s)
  );

  assign class_s = op_class(op_type);
  assign sub_s   = op_sub(op_type);
  assign shamt_s = val2[4:0];
  assign sum_s   = val1 + val2;
  assign diff_s  = val1 - val2;

  // Result mux over class and sub-op; anything undefined yields zero.
  always_comb begin
    result_s  = ZERO_V;
    is_jalr_s = 1'b0;
    case (class_s)
      OP_R_TYPE, OP_I_TYPE: begin
        case (sub_s)
          SUB_ADD:  result_s = sum_s;
          // I-type has no SUB encoding, so that code falls back to ADD.
          SUB_SUB:  result_s = (class_s == OP_I_TYPE) ? sum_s : diff_s;
          SUB_SLL:  result_s = val1 << shamt_s;
          SUB_SLT:  result_s = lt_s ? LSB_V : ZERO_V;
          SUB_SLTU: result_s = ltu_s ? LSB_V : ZERO_V;
          SUB_XOR:  result_s = val1 ^ val2;
          SUB_SRL:  result_s = val1 >> shamt_s;
          SUB_SRA:  result_s = $unsigned($signed(val1) >>> shamt_s);
          SUB_OR:   result_s = val1 | val2;
          SUB_AND:  result_s = val1 & val2;
          default:  result_s = ZERO_V;
        endcase
      end
      OP_B_TYPE: begin
        case (sub_s)
          SUB_BEQ:  result_s = eq_s   ? LSB_V : ZERO_V;
          SUB_BNE:  result_s = !eq_s  ? LSB_V : ZERO_V;
          SUB_BLT:  result_s = lt_s   ? LSB_V : ZERO_V;
          SUB_BGE:  result_s = !lt_s  ? LSB_V : ZERO_V;
          SUB_BLTU: result_s = ltu_s  ? LSB_V : ZERO_V;
          SUB_BGEU: result_s = !ltu_s ? LSB_V : ZERO_V;
          default:  result_s = ZERO_V;
        endcase
      end
      OP_MISC_TYPE: begin
        case (sub_s)
          SUB_LUI:   result_s = val1;
          SUB_AUIPC: result_s = sum_s;
          SUB_JAL:   result_s = sum_s;
          SUB_JALR: begin
            result_s  = sum_s & ~LSB_V;
            is_jalr_s = 1'b1;
          end
          default:   result_s = ZERO_V;
        endcase
      end
      default: begin
        result_s  = ZERO_V;
        is_jalr_s = 1'b0;
      end
    endcase
  end

  // CDB and fetch-redirect registers; rdy_in low freezes everything.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      aluReady   <= 1'b0;
      entry_out  <= {ROB_ID_WIDTH{1'b0}};
      val_out    <= ZERO_V;
      alu2if_pc  <= {ADDR_WIDTH{1'b0}};
      alu2if_con <= 1'b0;
    end else if (rdy_in) begin
      if (execute) begin
        aluReady   <= 1'b1;
        entry_out  <= entry;
        val_out    <= result_s;
        alu2if_con <= is_jalr_s;
        if (is_jalr_s) begin
          alu2if_pc <= result_s[ADDR_WIDTH-1:0];
        end
      end else begin
        aluReady   <= 1'b0;
        alu2if_con <= 1'b0;
      end
    end
  end

`ifdef ALU_TRACE_EN
  logic [31:0] cycle_cnt_r;

  // Free-running cycle count for trace timestamps.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      cycle_cnt_r <= 32'd0;
    end else begin
      cycle_cnt_r <= cycle_cnt_r + 32'd1;
    end
  end

  // Trace line for every operation that is actually accepted.
  always_ff @(posedge clk) begin
    if (rst_in && rdy_in && execute) begin
      $display("alu cyc=%0d pc=%h type=%h v1=%h v2=%h rob=%0d res=%h",
               cycle_cnt_r, nowPC, op_type, val1, val2, entry, result_s);
    end
  end
`else
  logic unused_pc_s;
  assign unused_pc_s = ^nowPC;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit with hand-computed expectations.
module tb_alu_unit;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        execute;
  logic [6:0]  op_type;
  logic [31:0] val1;
  logic [31:0] val2;
  logic [3:0]  entry;
  logic [31:0] nowPC;
  logic        aluReady;
  logic [3:0]  entry_out;
  logic [31:0] val_out;
  logic [31:0] alu2if_pc;
  logic        alu2if_con;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [6:0] R_ADD  = 7'h00, R_SUB = 7'h01, R_SLL = 7'h02, R_SLT = 7'h03;
  localparam logic [6:0] R_SLTU = 7'h04, R_XOR = 7'h05, R_SRL = 7'h06, R_SRA = 7'h07;
  localparam logic [6:0] R_OR   = 7'h08, R_AND = 7'h09, I_SUB = 7'h11, I_SRA = 7'h17;
  localparam logic [6:0] B_EQ   = 7'h20, B_NE  = 7'h21, B_LT  = 7'h24, B_GE  = 7'h25;
  localparam logic [6:0] B_LTU  = 7'h26, B_GEU = 7'h27, B_BAD = 7'h22;
  localparam logic [6:0] M_LUI  = 7'h30, M_AUIPC = 7'h31, M_JAL = 7'h32, M_JALR = 7'h33;
  localparam logic [6:0] X_BAD  = 7'h40, M_BAD = 7'h3F;

  alu_unit dut (
    .clk        (clk),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .execute    (execute),
    .op_type    (op_type),
    .val1       (val1),
    .val2       (val2),
    .entry      (entry),
    .nowPC      (nowPC),
    .aluReady   (aluReady),
    .entry_out  (entry_out),
    .val_out    (val_out),
    .alu2if_pc  (alu2if_pc),
    .alu2if_con (alu2if_con)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
    rdy_in  = 1'b1;
    execute = 1'b1;
    op_type = op;
    val1    = a;
    val2    = b;
    entry   = tag;
    nowPC   = nowPC + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy_in  = 1'b1;
    execute = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic op_val(input string tag, input logic [6:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    run_op(op, a, b, 4'd1);
    check(tag, val_out, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b0; execute = 1'b0; op_type = 7'h00;
    val1 = 32'h0; val2 = 32'h0; entry = 4'h0; nowPC = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, aluReady}, 32'h0);
    check("rst_entry", {28'b0, entry_out}, 32'h0);
    check("rst_val", val_out, 32'h0);
    check("rst_pc", alu2if_pc, 32'h0);
    check("rst_con", {31'b0, alu2if_con}, 32'h0);
    @(negedge clk);
    rst_in = 1'b1;

    run_op(R_ADD, 32'd5, 32'd7, 4'd3);
    check("add_ready", {31'b0, aluReady}, 32'h1);
    check("add_entry", {28'b0, entry_out}, 32'h3);
    check("add_val", val_out, 32'd12);

    // Asynchronous reset while a result is on the bus.
    rst_in = 1'b0;
    #1;
    check("arst_ready", {31'b0, aluReady}, 32'h0);
    check("arst_entry", {28'b0, entry_out}, 32'h0);
    check("arst_val", val_out, 32'h0);
    #2;
    rst_in = 1'b1;

    run_op(R_SUB, 32'd5, 32'd7, 4'd5);
    check("sub_val", val_out, 32'hFFFF_FFFE);
    check("sub_entry", {28'b0, entry_out}, 32'h5);
    op_val("isub_as_add", I_SUB, 32'd5, 32'd7, 32'd12);
    op_val("sra", R_SRA, 32'h8000_0000, 32'h21, 32'hC000_0000);
    op_val("isra", I_SRA, 32'hF000_0000, 32'h4, 32'hFF00_0000);
    op_val("srl", R_SRL, 32'h8000_0000, 32'h21, 32'h4000_0000);
    op_val("sll", R_SLL, 32'h1, 32'h24, 32'h10);
    op_val("xor", R_XOR, 32'hF0F0, 32'hFF00, 32'h0FF0);
    op_val("or", R_OR, 32'hF0F0, 32'hFF00, 32'hFFF0);
    op_val("and", R_AND, 32'hF0F0, 32'hFF00, 32'hF000);
    op_val("slt", R_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1);
    op_val("sltu", R_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0);
    op_val("bgeu", B_GEU, 32'h1, 32'hFFFF_FFFF, 32'h0);
    op_val("beq", B_EQ, 32'h4, 32'h4, 32'h1);
    op_val("bne", B_NE, 32'h4, 32'h4, 32'h0);
    op_val("blt", B_LT, 32'hFFFF_FFFF, 32'h1, 32'h1);
    op_val("bge", B_GE, 32'hFFFF_FFFF, 32'h1, 32'h0);
    op_val("bltu", B_LTU, 32'hFFFF_FFFF, 32'h1, 32'h0);
    op_val("add_wrap", R_ADD, 32'hFFFF_FFFF, 32'h2, 32'h1);
    op_val("auipc", M_AUIPC, 32'h1000, 32'h20, 32'h1020);
    op_val("lui", M_LUI, 32'hABCD_E000, 32'h55, 32'hABCD_E000);
    op_val("jal", M_JAL, 32'h4, 32'h100, 32'h104);
    check("jal_no_con", {31'b0, alu2if_con}, 32'h0);

    run_op(M_JALR, 32'h1003, 32'h4, 4'd7);
    check("jalr_val", val_out, 32'h1006);
    check("jalr_pc", alu2if_pc, 32'h1006);
    check("jalr_con", {31'b0, alu2if_con}, 32'h1);
    idle();
    check("jalr_con_drop", {31'b0, alu2if_con}, 32'h0);
    check("jalr_pc_hold", alu2if_pc, 32'h1006);

    run_op(M_JALR, 32'h2000, 32'h10, 4'd2);
    check("jalr2a_con", {31'b0, alu2if_con}, 32'h1);
    check("jalr2a_pc", alu2if_pc, 32'h2010);
    run_op(M_JALR, 32'h3001, 32'h0, 4'd4);
    check("jalr2b_con", {31'b0, alu2if_con}, 32'h1);
    check("jalr2b_pc", alu2if_pc, 32'h3000);
    run_op(R_ADD, 32'h1, 32'h1, 4'd6);
    check("after_jalr_con", {31'b0, alu2if_con}, 32'h0);
    check("after_jalr_pc", alu2if_pc, 32'h3000);

    run_op(X_BAD, 32'h1, 32'h2, 4'd9);
    check("bad_class_val", val_out, 32'h0);
    check("bad_class_ready", {31'b0, aluReady}, 32'h1);
    check("bad_class_entry", {28'b0, entry_out}, 32'h9);
    op_val("bad_branch", B_BAD, 32'h4, 32'h4, 32'h0);
    run_op(M_BAD, 32'h1, 32'h2, 4'd8);
    check("bad_misc_val", val_out, 32'h0);
    check("bad_misc_con", {31'b0, alu2if_con}, 32'h0);

    run_op(R_ADD, 32'd40, 32'd2, 4'd0);
    check("tag0_entry", {28'b0, entry_out}, 32'h0);
    check("tag0_val", val_out, 32'd42);

    idle();
    check("idle_ready", {31'b0, aluReady}, 32'h0);
    check("idle_val_hold", val_out, 32'd42);

    // Stall: a pending op must be neither taken nor lost while rdy_in is low.
    rdy_in  = 1'b0;
    execute = 1'b1;
    op_type = R_ADD;
    val1    = 32'd100;
    val2    = 32'd23;
    entry   = 4'd11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_ready", {31'b0, aluReady}, 32'h0);
      check("stall_val", val_out, 32'd42);
    end
    rdy_in = 1'b1;
    @(posedge clk);
    #1;
    check("resume_ready", {31'b0, aluReady}, 32'h1);
    check("resume_val", val_out, 32'd123);
    check("resume_entry", {28'b0, entry_out}, 32'd11);
    idle();
    check("exec0_ready", {31'b0, aluReady}, 32'h0);
    check("exec0_val", val_out, 32'd123);
    check("exec0_entry", {28'b0, entry_out}, 32'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
